// File: rtl/eth_helper_pkg.sv
// Shared types and width helpers for the Ethernet stream arbitration blocks.
package eth_helper_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int DEF_MAX_BEATS    = 256;
  localparam int DEF_STALL_CYCLES = 1024;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping modulo N.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] idx,
  output logic         valid
);

  int cand;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int k = 1; k <= N; k++) begin
      cand = int'(last) + k;
      if (cand >= N) cand = cand - N;
      if (!valid && req[cand]) begin
        idx   = W'(cand);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eth_stream_arbiter.sv
// Round-robin, packet-granular arbiter sharing one AXI-Stream master among NUM_SRC sources.
// state | meaning:  IDLE | no grant, picking next source;  GRANT | grant_id owns the port until tlast or stall
module eth_stream_arbiter
  import eth_helper_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int DATA_WIDTH   = 128,
  parameter int MAX_BEATS    = DEF_MAX_BEATS,
  parameter int STALL_CYCLES = DEF_STALL_CYCLES
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC-1:0]            src_in_progress,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]            src_ready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic [$clog2(NUM_SRC)-1:0]    grant_id,
  output logic                          busy,
  output logic                          err_overlength,
  output logic                          err_stall
);

  localparam int IW = idx_width(NUM_SRC);
  localparam int BW = cnt_width(MAX_BEATS);
  localparam int SW = idx_width(STALL_CYCLES);

  arb_state_t              state_q, state_d;
  logic [IW-1:0]           grant_q, last_q, pick_idx;
  logic                    pick_vld;
  logic [BW-1:0]           beat_q;
  logic [SW-1:0]           stall_q;
  logic [DATA_WIDTH-1:0]   data_q, g_data;
  logic                    ovl_q, stall_err_q;
  logic                    in_grant, g_valid, g_inprog, beat, forced_last, tlast, stall_hit;

  rr_pick #(.N(NUM_SRC), .W(IW)) u_pick (
    .req   (src_valid),
    .last  (last_q),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

  always_comb begin
    in_grant    = (state_q == GRANT);
    g_valid     = src_valid[grant_q];
    g_inprog    = src_in_progress[grant_q];
    g_data      = src_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    beat        = in_grant & g_valid & m_axis_tready;
    forced_last = (beat_q == BW'(MAX_BEATS - 1));
    tlast       = in_grant & (~g_inprog | forced_last);
    stall_hit   = in_grant & ~beat & (stall_q == SW'(STALL_CYCLES - 1));

    src_ready = '0;
    if (in_grant) src_ready[grant_q] = m_axis_tready;
    m_axis_tvalid = in_grant & g_valid;
    m_axis_tlast  = tlast;
    m_axis_tdata  = in_grant ? g_data : data_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_vld) state_d = GRANT;
      GRANT:   if ((beat & tlast) | stall_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      last_q      <= IW'(NUM_SRC - 1);
      beat_q      <= '0;
      stall_q     <= '0;
      data_q      <= '0;
      ovl_q       <= 1'b0;
      stall_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ovl_q       <= 1'b0;
      stall_err_q <= 1'b0;
      if (!in_grant && pick_vld) begin
        grant_q <= pick_idx;
        beat_q  <= '0;
        stall_q <= '0;
      end
      if (in_grant) begin
        data_q <= g_data;
        if (beat) begin
          beat_q  <= beat_q + BW'(1);
          stall_q <= '0;
          if (tlast) begin
            last_q <= grant_q;
            ovl_q  <= forced_last & g_inprog;
          end
        end else begin
          if (stall_q != '1) stall_q <= stall_q + SW'(1);
          // A stalled grant is dropped without tlast; the framer discards the fragment.
          if (stall_hit) begin
            last_q      <= grant_q;
            stall_err_q <= 1'b1;
          end
        end
      end
    end
  end

  assign grant_id       = grant_q;
  assign busy           = in_grant;
  assign err_overlength = ovl_q;
  assign err_stall      = stall_err_q;

endmodule

// File: tb/tb_eth_stream_arbiter.sv
// Self-checking bench for eth_stream_arbiter: directed scenarios plus a randomized run against a packet-level model.
module tb_eth_stream_arbiter;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int MAXB  = 8;
  localparam int STALL = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    src_valid, src_in_progress, src_ready;
  logic [N*DW-1:0] src_data;
  logic [DW-1:0]   m_axis_tdata;
  logic            m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [1:0]      grant_id;
  logic            busy, err_overlength, err_stall;

  int n_checks = 0;
  int n_pass   = 0;

  // Source generators: beats left in the current packet, beats sent so far, and a valid mask.
  int         rem[N];
  int         seq[N];
  bit         mute[N];
  logic [N-1:0] xfer;

  eth_stream_arbiter #(
    .NUM_SRC(N), .DATA_WIDTH(DW), .MAX_BEATS(MAXB), .STALL_CYCLES(STALL)
  ) dut (
    .clk(clk), .reset(reset),
    .src_valid(src_valid), .src_in_progress(src_in_progress), .src_data(src_data),
    .src_ready(src_ready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .grant_id(grant_id), .busy(busy), .err_overlength(err_overlength), .err_stall(err_stall)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] beat_word(input int s, input int k);
    return {8'(s), 24'(k)};
  endfunction

  function automatic int rr_ref(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      src_valid[i]            = (rem[i] > 0) && !mute[i];
      src_in_progress[i]      = (rem[i] > 1);
      src_data[i*DW +: DW]    = beat_word(i, seq[i]);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    xfer = src_valid & src_ready;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (xfer[i]) begin
        rem[i]--;
        seq[i]++;
      end
    xfer = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_axis_tready = 1'b1;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0; seq[i] = 0; mute[i] = 0;
    end
    xfer = '0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    drive();
    sample();
    n_checks++; if (src_ready !== 4'b0) $display("FAIL rst_src_ready got %b exp 0000", src_ready); else n_pass++;
    n_checks++; if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) $display("FAIL rst_tvalid_tlast got %b%b exp 00", m_axis_tvalid, m_axis_tlast); else n_pass++;
    n_checks++; if (m_axis_tdata !== '0) $display("FAIL rst_tdata got %h exp 0", m_axis_tdata); else n_pass++;
    n_checks++; if (grant_id !== 2'd0 || busy !== 1'b0) $display("FAIL rst_grant_busy got %0d/%b exp 0/0", grant_id, busy); else n_pass++;
    n_checks++; if (err_overlength !== 1'b0 || err_stall !== 1'b0) $display("FAIL rst_err got %b%b exp 00", err_overlength, err_stall); else n_pass++;
  endtask

  task automatic test_single();
    int beats = 0;
    int first = -1;
    do_reset();
    rem[2] = 3;
    drive();
    sample();
    n_checks++; if (busy !== 1'b0 || src_ready !== 4'b0) $display("FAIL single_lat0 got busy=%b ready=%b exp 0/0000", busy, src_ready); else n_pass++;
    for (int c = 1; c <= 8; c++) begin
      advance(); drive(); sample();
      if (m_axis_tvalid && m_axis_tready) begin
        if (first < 0) first = c;
        n_checks++; if (grant_id !== 2'd2) $display("FAIL single_gid got %0d exp 2", grant_id); else n_pass++;
        n_checks++; if (m_axis_tdata !== beat_word(2, beats)) $display("FAIL single_data got %h exp %h", m_axis_tdata, beat_word(2, beats)); else n_pass++;
        n_checks++; if (m_axis_tlast !== (beats == 2)) $display("FAIL single_tlast beat %0d got %b", beats, m_axis_tlast); else n_pass++;
        beats++;
      end
    end
    n_checks++; if (first !== 1) $display("FAIL single_latency got %0d exp 1", first); else n_pass++;
    n_checks++; if (beats !== 3) $display("FAIL single_beats got %0d exp 3", beats); else n_pass++;
    n_checks++; if (busy !== 1'b0 || m_axis_tvalid !== 1'b0 || m_axis_tdata !== beat_word(2, 2))
      $display("FAIL single_idle_hold got busy=%b tvalid=%b data=%h exp 0/0/%h", busy, m_axis_tvalid, m_axis_tdata, beat_word(2, 2)); else n_pass++;
  endtask

  task automatic test_round_robin();
    int gc[$];
    int gid[$];
    do_reset();
    for (int i = 0; i < N; i++) rem[i] = 1;
    drive();
    for (int c = 0; c < 16; c++) begin
      sample();
      if (m_axis_tvalid && m_axis_tready) begin
        gc.push_back(c);
        gid.push_back(int'(grant_id));
      end
      advance();
      for (int i = 0; i < N; i++) if (rem[i] == 0) rem[i] = 1;
      drive();
    end
    n_checks++; if (gc.size() < 5) $display("FAIL rr_count got %0d exp >=5", gc.size()); else n_pass++;
    for (int k = 0; k < 5 && k < gc.size(); k++) begin
      n_checks++; if (gid[k] !== k % N) $display("FAIL rr_order pkt %0d got %0d exp %0d", k, gid[k], k % N); else n_pass++;
      if (k > 0) begin
        n_checks++; if (gc[k] - gc[k-1] !== 2) $display("FAIL rr_gap pkt %0d got %0d exp 2", k, gc[k] - gc[k-1]); else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int k = 0;
    int n_src = 0;
    do_reset();
    rem[1] = 4;
    drive();
    for (int c = 0; c < 14; c++) begin
      sample();
      if (xfer[1]) n_src++;
      if (busy && m_axis_tvalid) begin
        n_checks++; if (m_axis_tdata !== beat_word(1, k)) $display("FAIL bp_data c%0d got %h exp %h", c, m_axis_tdata, beat_word(1, k)); else n_pass++;
        n_checks++; if (src_ready !== (4'(m_axis_tready) << 1)) $display("FAIL bp_ready c%0d got %b", c, src_ready); else n_pass++;
        if (m_axis_tready) begin
          n_checks++; if (m_axis_tlast !== (k == 3)) $display("FAIL bp_tlast beat %0d got %b", k, m_axis_tlast); else n_pass++;
          k++;
        end
      end
      advance();
      m_axis_tready = pat[c % 4];
      drive();
    end
    m_axis_tready = 1'b1;
    n_checks++; if (k !== 4) $display("FAIL bp_out_beats got %0d exp 4", k); else n_pass++;
    n_checks++; if (n_src !== 4) $display("FAIL bp_src_beats got %0d exp 4", n_src); else n_pass++;
  endtask

  task automatic test_overlength();
    int k = 0, c8 = -1, c9 = -1, n_err = 0, err_c = -1;
    bit gap_busy = 1'b1;
    do_reset();
    rem[0] = 12;
    drive();
    for (int c = 0; c < 20; c++) begin
      sample();
      if (err_overlength) begin
        n_err++; err_c = c; gap_busy = busy;
      end
      if (busy && m_axis_tvalid && m_axis_tready) begin
        n_checks++; if (m_axis_tdata !== beat_word(0, k)) $display("FAIL ovl_data beat %0d got %h", k, m_axis_tdata); else n_pass++;
        n_checks++; if (m_axis_tlast !== (k == MAXB-1 || k == 11)) $display("FAIL ovl_tlast beat %0d got %b", k, m_axis_tlast); else n_pass++;
        if (k == MAXB-1) c8 = c;
        if (k == MAXB) c9 = c;
        k++;
      end
      advance(); drive();
    end
    n_checks++; if (k !== 12) $display("FAIL ovl_beats got %0d exp 12", k); else n_pass++;
    n_checks++; if (n_err !== 1) $display("FAIL ovl_pulses got %0d exp 1", n_err); else n_pass++;
    n_checks++; if (err_c !== c8 + 1) $display("FAIL ovl_pulse_cycle got %0d exp %0d", err_c, c8 + 1); else n_pass++;
    n_checks++; if (gap_busy !== 1'b0) $display("FAIL ovl_gap_busy got %b exp 0", gap_busy); else n_pass++;
    n_checks++; if (c9 !== c8 + 2) $display("FAIL ovl_regrant got %0d exp %0d", c9, c8 + 2); else n_pass++;
  endtask

  task automatic test_stall();
    int beat_c = -1, err_c = -1, regrant_c = -1, n_err = 0, n_b2 = 0, n_tlast = 0;
    bit busy_at_err = 1'b1;
    do_reset();
    rem[2] = 5;
    drive();
    for (int c = 0; c < 30; c++) begin
      sample();
      if (busy && grant_id == 2'd2 && m_axis_tvalid && m_axis_tready) begin
        n_b2++;
        if (beat_c < 0) beat_c = c;
        if (m_axis_tlast) n_tlast++;
      end
      if (err_stall) begin
        n_err++;
        if (err_c < 0) begin err_c = c; busy_at_err = busy; end
      end
      if (busy && grant_id == 2'd1 && regrant_c < 0) regrant_c = c;
      advance();
      if (beat_c >= 0) mute[2] = 1'b1;
      if (c == 1) rem[1] = 1;
      drive();
    end
    n_checks++; if (n_b2 !== 1 || n_tlast !== 0) $display("FAIL stall_beats got %0d/%0d exp 1/0", n_b2, n_tlast); else n_pass++;
    n_checks++; if (n_err !== 1) $display("FAIL stall_pulses got %0d exp 1", n_err); else n_pass++;
    n_checks++; if (err_c !== beat_c + STALL + 1) $display("FAIL stall_cycle got %0d exp %0d", err_c, beat_c + STALL + 1); else n_pass++;
    n_checks++; if (busy_at_err !== 1'b0) $display("FAIL stall_idle got busy=%b exp 0", busy_at_err); else n_pass++;
    n_checks++; if (regrant_c !== err_c + 1) $display("FAIL stall_regrant got %0d exp %0d", regrant_c, err_c + 1); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    rem[3] = 5;
    drive();
    sample();
    advance(); drive(); sample();
    n_checks++; if (!(m_axis_tvalid && m_axis_tready && grant_id == 2'd3)) $display("FAIL rmid_beat1 got tvalid=%b gid=%0d", m_axis_tvalid, grant_id); else n_pass++;
    advance(); reset = 1'b1; drive(); sample();
    advance(); reset = 1'b0;
    for (int i = 0; i < N; i++) begin rem[i] = 0; seq[i] = 0; end
    rem[0] = 1; rem[3] = 2;
    drive(); sample();
    n_checks++; if (src_ready !== 4'b0 || m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0)
      $display("FAIL rmid_outputs got ready=%b tvalid=%b tlast=%b exp 0", src_ready, m_axis_tvalid, m_axis_tlast); else n_pass++;
    n_checks++; if (m_axis_tdata !== '0 || busy !== 1'b0 || grant_id !== 2'd0)
      $display("FAIL rmid_state got data=%h busy=%b gid=%0d exp 0", m_axis_tdata, busy, grant_id); else n_pass++;
    advance(); drive(); sample();
    n_checks++; if (busy !== 1'b1 || grant_id !== 2'd0) $display("FAIL rmid_first_grant got busy=%b gid=%0d exp 1/0", busy, grant_id); else n_pass++;
  endtask

  task automatic test_random();
    bit   mb = 1'b0;
    int   mg = 0, mlast = N-1, mcnt = 0, nobeat = 0;
    bit   ovl_pend = 1'b0, ovl_next, beat, exp_last;
    int   eseq[N];
    do_reset();
    for (int i = 0; i < N; i++) eseq[i] = 0;
    drive();
    for (int c = 0; c < 1500; c++) begin
      sample();
      ovl_next = 1'b0;
      n_checks++; if (err_overlength !== ovl_pend) $display("FAIL rnd_ovl c%0d got %b exp %b", c, err_overlength, ovl_pend); else n_pass++;
      n_checks++; if (err_stall !== 1'b0) $display("FAIL rnd_stall c%0d got 1 exp 0", c); else n_pass++;
      if (mb) begin
        n_checks++; if (busy !== 1'b1 || grant_id !== 2'(mg)) $display("FAIL rnd_grant c%0d got %b/%0d exp 1/%0d", c, busy, grant_id, mg); else n_pass++;
        n_checks++; if (src_ready !== (4'(m_axis_tready) << mg)) $display("FAIL rnd_ready c%0d got %b", c, src_ready); else n_pass++;
        n_checks++; if (m_axis_tvalid !== src_valid[mg]) $display("FAIL rnd_tvalid c%0d got %b exp %b", c, m_axis_tvalid, src_valid[mg]); else n_pass++;
        beat = src_valid[mg] && m_axis_tready;
        if (beat) begin
          exp_last = (rem[mg] == 1) || (mcnt == MAXB-1);
          n_checks++; if (m_axis_tdata !== beat_word(mg, eseq[mg])) $display("FAIL rnd_data c%0d got %h exp %h", c, m_axis_tdata, beat_word(mg, eseq[mg])); else n_pass++;
          n_checks++; if (m_axis_tlast !== exp_last) $display("FAIL rnd_tlast c%0d got %b exp %b", c, m_axis_tlast, exp_last); else n_pass++;
          ovl_next = (mcnt == MAXB-1) && (rem[mg] > 1);
          eseq[mg]++;
          mcnt++;
          nobeat = 0;
          if (exp_last) begin mb = 1'b0; mlast = mg; end
        end else begin
          nobeat++;
        end
      end else begin
        n_checks++; if (busy !== 1'b0 || m_axis_tvalid !== 1'b0) $display("FAIL rnd_idle c%0d got busy=%b tvalid=%b exp 0/0", c, busy, m_axis_tvalid); else n_pass++;
        nobeat = 0;
        if (src_valid != '0) begin
          mg = rr_ref(src_valid, mlast);
          mb = 1'b1;
          mcnt = 0;
        end
      end
      ovl_pend = ovl_next;
      advance();
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 2) == 0) rem[i] = $urandom_range(1, 12);
        mute[i] = ($urandom_range(0, 7) == 0);
      end
      m_axis_tready = ($urandom_range(0, 3) != 0);
      if (nobeat >= 6) begin
        m_axis_tready = 1'b1;
        for (int i = 0; i < N; i++) mute[i] = 1'b0;
      end
      drive();
    end
  endtask

  initial begin
    m_axis_tready = 1'b1;
    for (int i = 0; i < N; i++) begin rem[i] = 0; seq[i] = 0; mute[i] = 0; end
    xfer = '0;
    drive();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_overlength();
    test_stall();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
